// File: rtl/frequency_pattern_generator_pkg.sv
// Shared constants and types for the frequency pattern generator: register-port
// opcodes, register indices and the sequencer state encoding.
package frequency_pattern_generator_pkg;

   localparam logic [1:0] REGISTER_NO_OPERATION   = 2'd0;
   localparam logic [1:0] REGISTER_READ_OPERATION = 2'd1;

   localparam int         FREQUENCY_REGISTERS_NUMBER = 6;
   localparam logic [2:0] FIRST_REGISTER_INDEX       = 3'd1;
   localparam logic [2:0] LAST_REGISTER_INDEX        = 3'(FREQUENCY_REGISTERS_NUMBER);
   localparam int         PIXEL_CHANNELS             = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQUEST,
      ST_CAPTURE,
      ST_DONE
   } fsm_state_t;

   // A zero frequency yields a zero half-period, which parks the channel low.
   function automatic logic [31:0] half_period_of(input int unsigned clock_hz,
                                                  input int unsigned freq_hz);
      if (freq_hz == 0) return 32'd0;
      return 32'(clock_hz / (2 * freq_hz));
   endfunction

endpackage

// File: rtl/frequency_pattern_generator_toggle_channel.sv
// One square-wave lane: toggles its output every half_period clocks while enabled.
module frequency_toggle_channel (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] half_period,
   input  logic        restart,
   output logic        sample
);

   logic [31:0] count_q, count_d;
   logic        sample_q, sample_d;

   // Restart realigns the phase without disturbing the current level.
   always_comb begin
      count_d  = count_q;
      sample_d = sample_q;
      if (!enable || half_period == 32'd0) begin
         count_d  = 32'd0;
         sample_d = 1'b0;
      end else if (restart) begin
         count_d = 32'd0;
      end else if (count_q == half_period - 32'd1) begin
         count_d  = 32'd0;
         sample_d = ~sample_q;
      end else begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q  <= 32'd0;
         sample_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         sample_q <= sample_d;
      end
   end

   assign sample = sample_q;

endmodule

// File: rtl/frequency_pattern_generator.sv
// Reads six half-period words from the register bank, commits them atomically and
// drives three square-wave sample lines at the F0/F1 rate chosen per pixel.
module frequency_pattern_generator
   import frequency_pattern_generator_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY   = 100000000,
   parameter int unsigned PIXEL0_FREQUENCY0 = 5000,
   parameter int unsigned PIXEL0_FREQUENCY1 = 10000,
   parameter int unsigned PIXEL1_FREQUENCY0 = 15000,
   parameter int unsigned PIXEL1_FREQUENCY1 = 20000,
   parameter int unsigned PIXEL2_FREQUENCY0 = 25000,
   parameter int unsigned PIXEL2_FREQUENCY1 = 30000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic        enable,
   input  logic [2:0]  select,
   output logic [1:0]  register_operation,
   output logic [7:0]  register_number,
   input  logic [31:0] register_read,
   output logic [2:0]  sample,
   output logic        loaded
);

   localparam logic [31:0] DEFAULT_HALF_PERIOD [FREQUENCY_REGISTERS_NUMBER] = '{
      half_period_of(CLOCK_FREQUENCY, PIXEL0_FREQUENCY0),
      half_period_of(CLOCK_FREQUENCY, PIXEL0_FREQUENCY1),
      half_period_of(CLOCK_FREQUENCY, PIXEL1_FREQUENCY0),
      half_period_of(CLOCK_FREQUENCY, PIXEL1_FREQUENCY1),
      half_period_of(CLOCK_FREQUENCY, PIXEL2_FREQUENCY0),
      half_period_of(CLOCK_FREQUENCY, PIXEL2_FREQUENCY1)
   };

   fsm_state_t  state_q;
   logic [2:0]  index_q;
   logic [1:0]  operation_q;
   logic [7:0]  number_q;
   logic        loaded_q;

   logic [31:0] shadow_q [FREQUENCY_REGISTERS_NUMBER];
   logic [31:0] shadow_d [FREQUENCY_REGISTERS_NUMBER];
   logic [31:0] active_q [FREQUENCY_REGISTERS_NUMBER];
   logic [31:0] active_d [FREQUENCY_REGISTERS_NUMBER];
   logic [2:0]  select_q, select_d;

   logic [2:0]  restart;
   logic [31:0] half_period [PIXEL_CHANNELS];

   // Each register is requested for one cycle and captured the cycle after.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         index_q     <= FIRST_REGISTER_INDEX;
         operation_q <= REGISTER_NO_OPERATION;
         number_q    <= 8'd0;
         loaded_q    <= 1'b0;
      end else begin
         loaded_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (load) begin
                  state_q     <= ST_REQUEST;
                  index_q     <= FIRST_REGISTER_INDEX;
                  operation_q <= REGISTER_READ_OPERATION;
                  number_q    <= 8'(FIRST_REGISTER_INDEX);
               end
            end
            ST_REQUEST: begin
               state_q     <= ST_CAPTURE;
               operation_q <= REGISTER_NO_OPERATION;
               number_q    <= 8'd0;
            end
            ST_CAPTURE: begin
               if (index_q == LAST_REGISTER_INDEX) begin
                  state_q  <= ST_DONE;
                  loaded_q <= 1'b1;
               end else begin
                  state_q     <= ST_REQUEST;
                  index_q     <= index_q + 3'd1;
                  operation_q <= REGISTER_READ_OPERATION;
                  number_q    <= 8'(index_q) + 8'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      select_d = select;
      if (state_q == ST_CAPTURE) begin
         shadow_d[index_q - 3'd1] = register_read;
      end
      if (state_q == ST_DONE) begin
         active_d = shadow_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         active_q <= DEFAULT_HALF_PERIOD;
         select_q <= 3'b000;
      end else begin
         active_q <= active_d;
         select_q <= select_d;
      end
   end

   // Shadows are fully rewritten by every completed sequence before they are used.
   always_ff @(posedge clock) begin
      shadow_q <= shadow_d;
   end

   for (genvar i = 0; i < PIXEL_CHANNELS; i++) begin : g_channel
      assign restart[i]     = (state_q == ST_DONE) || (select[i] != select_q[i]);
      assign half_period[i] = select[i] ? active_q[2*i+1] : active_q[2*i];

      frequency_toggle_channel u_channel (
         .clock       (clock),
         .reset       (reset),
         .enable      (enable),
         .half_period (half_period[i]),
         .restart     (restart[i]),
         .sample      (sample[i])
      );
   end

   assign register_operation = operation_q;
   assign register_number    = number_q;
   assign loaded             = loaded_q;

endmodule
